// File: rtl/sysid_boot_checker_if.sv
`default_nettype none
// ============================================================================
// sysid_boot_checker_if : sysid read master and status slave signal bundle
// Rev 1.0
// ============================================================================
interface sysid_boot_checker_if;
    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    // Checker side: master towards the sysid slave, slave towards the CPU.
    modport master (
        output m_address, m_read, s_readdata,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        input  s_address, s_read, s_write, s_writedata
    );

    modport slave (
        input  m_address, m_read, s_readdata,
        output m_waitrequest, m_readdata, m_readdatavalid,
        output s_address, s_read, s_write, s_writedata
    );
endinterface
`default_nettype wire

// File: rtl/sysid_boot_checker.sv
`default_nettype none
// ============================================================================
// sysid_boot_checker : reads sysid ID/timestamp after reset, flags image mismatch
// Rev 1.0
// ============================================================================
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd305419896,
    parameter logic [31:0] EXPECTED_TS    = 32'd1413884236,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  wire logic            clock_i,
    input  wire logic            reset_n_i,
    sysid_boot_checker_if.master bus,
    output logic                 sysid_ok_o,
    output logic                 sysid_fail_o
);
    localparam int unsigned        c_cnt_w    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_REQ_ID  = 3'd0,
        S_WAIT_ID = 3'd1,
        S_REQ_TS  = 3'd2,
        S_WAIT_TS = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic               m_read_q;
    logic               m_address_q;
    logic [31:0]        cap_id_q;
    logic [31:0]        cap_ts_q;
    logic               done_q;
    logic               ok_q;
    logic               fail_q;
    logic               id_mis_q;
    logic               ts_mis_q;
    logic               timeout_q;
    logic               busy_q;

    logic w_in_req;
    logic w_in_wait;
    logic w_is_ts;
    logic w_accept;
    logic w_resp;
    logic w_expired;
    logic w_restart;
    logic w_id_mis;
    logic w_ts_mis;
    logic w_unused_wdata;

    assign w_in_req  = (state_q == S_REQ_ID) || (state_q == S_REQ_TS);
    assign w_in_wait = (state_q == S_WAIT_ID) || (state_q == S_WAIT_TS);
    assign w_is_ts   = (state_q == S_REQ_TS) || (state_q == S_WAIT_TS);
    // The first REQ_ID cycle after reset has m_read low, so nothing is accepted there.
    assign w_accept  = w_in_req && m_read_q && !bus.m_waitrequest;
    assign w_resp    = bus.m_readdatavalid && (w_accept || w_in_wait);
    assign w_expired = (cnt_q == c_cnt_last);
    assign w_restart = (state_q == S_DONE) && bus.s_write &&
                       (bus.s_address == 2'd3) && bus.s_writedata[0];
    assign w_id_mis  = (cap_id_q != EXPECTED_ID);
    assign w_ts_mis  = (bus.m_readdata != EXPECTED_TS);
    assign w_unused_wdata = ^bus.s_writedata[31:1];

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_REQ_ID;
            cnt_q       <= '0;
            m_read_q    <= 1'b0;
            m_address_q <= 1'b0;
            cap_id_q    <= '0;
            cap_ts_q    <= '0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            fail_q      <= 1'b0;
            id_mis_q    <= 1'b0;
            ts_mis_q    <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_REQ_ID, S_WAIT_ID, S_REQ_TS, S_WAIT_TS: begin
                    cnt_q  <= cnt_q + 1'b1;
                    busy_q <= 1'b1;
                    if (w_resp) begin
                        cnt_q <= '0;
                        if (w_is_ts) begin
                            // Mismatch flags use the incoming TS word so DONE is entered with final results.
                            cap_ts_q <= bus.m_readdata;
                            state_q  <= S_DONE;
                            m_read_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            id_mis_q <= w_id_mis;
                            ts_mis_q <= w_ts_mis;
                            ok_q     <= !w_id_mis && !w_ts_mis;
                            fail_q   <= w_id_mis || w_ts_mis;
                        end else begin
                            cap_id_q    <= bus.m_readdata;
                            state_q     <= S_REQ_TS;
                            m_read_q    <= 1'b1;
                            m_address_q <= 1'b1;
                        end
                    end else if (w_expired) begin
                        state_q   <= S_DONE;
                        m_read_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        fail_q    <= 1'b1;
                    end else if (w_accept) begin
                        state_q  <= w_is_ts ? S_WAIT_TS : S_WAIT_ID;
                        m_read_q <= 1'b0;
                    end else if (w_in_req) begin
                        m_read_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_restart) begin
                        state_q     <= S_REQ_ID;
                        cnt_q       <= '0;
                        m_read_q    <= 1'b1;
                        m_address_q <= 1'b0;
                        cap_id_q    <= '0;
                        cap_ts_q    <= '0;
                        done_q      <= 1'b0;
                        ok_q        <= 1'b0;
                        fail_q      <= 1'b0;
                        id_mis_q    <= 1'b0;
                        ts_mis_q    <= 1'b0;
                        timeout_q   <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                default: state_q <= S_REQ_ID;
            endcase
        end
    end

    always_comb begin
        bus.s_readdata = '0;
        if (bus.s_read) begin
            case (bus.s_address)
                2'd0:    bus.s_readdata = {26'd0, busy_q, timeout_q, ts_mis_q, id_mis_q, ok_q, done_q};
                2'd1:    bus.s_readdata = cap_id_q;
                2'd2:    bus.s_readdata = cap_ts_q;
                default: bus.s_readdata = '0;
            endcase
        end
    end

    assign bus.m_read    = m_read_q;
    assign bus.m_address = m_address_q;
    assign sysid_ok_o    = ok_q;
    assign sysid_fail_o  = fail_q;
endmodule
`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
`default_nettype none
// ============================================================================
// tb_sysid_boot_checker : directed scoreboard bench with a behavioural sysid slave
// Rev 1.0
// ============================================================================
module tb_sysid_boot_checker;
    localparam logic [31:0] c_exp_id  = 32'd305419896;
    localparam logic [31:0] c_exp_ts  = 32'd1413884236;
    localparam int unsigned c_timeout = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sysid_ok;
    logic sysid_fail;

    always #5 clk = ~clk;

    sysid_boot_checker_if bus ();

    sysid_boot_checker #(
        .EXPECTED_ID   (c_exp_id),
        .EXPECTED_TS   (c_exp_ts),
        .TIMEOUT_CYCLES(c_timeout)
    ) dut (
        .clock_i     (clk),
        .reset_n_i   (rst_n),
        .bus         (bus),
        .sysid_ok_o  (sysid_ok),
        .sysid_fail_o(sysid_fail)
    );

    typedef struct {
        logic        ok;
        logic        fail;
        logic [31:0] status;
        logic [31:0] cap_id;
        logic [31:0] cap_ts;
    } result_t;

    result_t exp_res_q[$];
    logic    exp_addr_q[$];

    int errors = 0;
    int checks = 0;

    int          rsp_stall    = 0;
    int          rsp_delay    = 0;
    bit          rsp_enable   = 1'b1;
    bit          timeout_mode = 1'b0;
    logic [31:0] rsp_id       = c_exp_id;
    logic [31:0] rsp_ts       = c_exp_ts;
    int          pend_left    = 0;
    logic [31:0] pend_data    = '0;
    int          accept_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Sysid slave model: optional waitrequest stall, then response immediately or after a delay.
    initial begin : responder
        int          stall_left;
        bit          in_req;
        logic [31:0] data;
        stall_left = 0;
        in_req     = 1'b0;
        bus.m_waitrequest   = 1'b0;
        bus.m_readdatavalid = 1'b0;
        bus.m_readdata      = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_readdatavalid = 1'b0;
            bus.m_waitrequest   = 1'b0;
            if (pend_left > 0) begin
                pend_left--;
                if (pend_left == 0) begin
                    bus.m_readdatavalid = 1'b1;
                    bus.m_readdata      = pend_data;
                end
            end
            if (!bus.m_read) begin
                if (in_req && rst_n && !timeout_mode)
                    check("read_held", 32'(bus.m_read), 32'd1);
                in_req = 1'b0;
            end else begin
                if (!in_req) begin
                    in_req     = 1'b1;
                    stall_left = rsp_stall;
                end
                check("read_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0)
                    check("req_addr", 32'(bus.m_address), 32'(exp_addr_q[0]));
                if (stall_left > 0) begin
                    stall_left--;
                    bus.m_waitrequest = 1'b1;
                end else begin
                    in_req = 1'b0;
                    accept_count++;
                    data = bus.m_address ? rsp_ts : rsp_id;
                    if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
                    if (rsp_enable) begin
                        if (rsp_delay == 0) begin
                            bus.m_readdatavalid = 1'b1;
                            bus.m_readdata      = data;
                        end else begin
                            pend_left = rsp_delay;
                            pend_data = data;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [31:0] data);
        tick();
        bus.s_read    = 1'b1;
        bus.s_write   = 1'b0;
        bus.s_address = addr;
        @(negedge clk);
        data = bus.s_readdata;
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
        tick();
        bus.s_write     = 1'b1;
        bus.s_address   = addr;
        bus.s_writedata = data;
        tick();
        bus.s_write = 1'b0;
    endtask

    task automatic expect_run(input logic ok, input logic fail, input logic [31:0] status,
                              input logic [31:0] cid, input logic [31:0] cts, input int reads);
        result_t r;
        r.ok = ok; r.fail = fail; r.status = status; r.cap_id = cid; r.cap_ts = cts;
        exp_res_q.push_back(r);
        for (int i = 0; i < reads; i++) exp_addr_q.push_back(i[0]);
    endtask

    task automatic wait_done(input string tag, input int limit, output int n);
        bit seen;
        seen = 1'b0;
        n    = limit + 1;
        for (int i = 1; i <= limit && !seen; i++) begin
            @(negedge clk);
            if (sysid_ok || sysid_fail) begin
                seen = 1'b1;
                n    = i;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_accepts(input string tag, input int target, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (accept_count >= target) seen = 1'b1;
        end
        check({tag, "_accept_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic compare_result(input string tag);
        result_t     e;
        logic [31:0] d;
        check({tag, "_sb_size"}, 32'(exp_res_q.size()), 32'd1);
        if (exp_res_q.size() != 0) begin
            e = exp_res_q.pop_front();
            check({tag, "_ok_pin"},   32'(sysid_ok),   32'(e.ok));
            check({tag, "_fail_pin"}, 32'(sysid_fail), 32'(e.fail));
            check({tag, "_m_read"},   32'(bus.m_read), 32'd0);
            read_reg(2'd0, d); check({tag, "_status"}, d, e.status);
            read_reg(2'd1, d); check({tag, "_cap_id"}, d, e.cap_id);
            read_reg(2'd2, d); check({tag, "_cap_ts"}, d, e.cap_ts);
        end
    endtask

    initial begin : stimulus
        int          n;
        int          base;
        logic [31:0] d;
        bus.s_address   = 2'd0;
        bus.s_read      = 1'b1;
        bus.s_write     = 1'b0;
        bus.s_writedata = '0;

        // Reset state
        repeat (3) tick();
        check("rst_m_read",    32'(bus.m_read),    32'd0);
        check("rst_m_address", 32'(bus.m_address), 32'd0);
        check("rst_ok",        32'(sysid_ok),      32'd0);
        check("rst_fail",      32'(sysid_fail),    32'd0);
        check("rst_status",    bus.s_readdata,     32'd0);

        // Zero-latency sysid with matching words
        expect_run(1'b1, 1'b0, 32'h03, c_exp_id, c_exp_ts, 2);
        tick();
        rst_n = 1'b1;
        wait_done("zl", 20, n);
        check("zl_latency_le4", 32'(n <= 4), 32'd1);
        compare_result("zl");

        // Restart with a wrong timestamp; same-cycle read sees pre-restart state
        rsp_ts = c_exp_ts + 32'd1;
        expect_run(1'b0, 1'b1, 32'h09, c_exp_id, c_exp_ts + 32'd1, 2);
        tick();
        bus.s_write = 1'b1; bus.s_read = 1'b1; bus.s_address = 2'd3; bus.s_writedata = 32'd1;
        @(negedge clk);
        check("rs_pre_ok",   32'(sysid_ok),  32'd1);
        check("rs_ctrl_rd",  bus.s_readdata, 32'd0);
        tick();
        bus.s_write = 1'b0; bus.s_address = 2'd0;
        @(negedge clk);
        check("rs_busy_status", bus.s_readdata, 32'h20);
        check("rs_busy_ok",     32'(sysid_ok),  32'd0);
        wait_done("ts_bad", 20, n);
        compare_result("ts_bad");

        // Stalled fabric with delayed response; restart write while busy is ignored
        rsp_ts = c_exp_ts; rsp_stall = 5; rsp_delay = 3;
        expect_run(1'b1, 1'b0, 32'h03, c_exp_id, c_exp_ts, 2);
        base = accept_count;
        write_reg(2'd3, 32'd1);
        wait_accepts("slow", base + 1, 40);
        write_reg(2'd3, 32'd1);
        read_reg(2'd0, d);
        check("slow_busy_status", d, 32'h20);
        wait_done("slow", 100, n);
        compare_result("slow");

        // Reset asserted while waiting for the timestamp response
        exp_addr_q.push_back(1'b0);
        exp_addr_q.push_back(1'b1);
        base = accept_count;
        write_reg(2'd3, 32'd1);
        wait_accepts("mid", base + 2, 60);
        tick();
        check("mid_pre_addr", 32'(bus.m_address), 32'd1);
        rst_n = 1'b0; bus.s_read = 1'b1; bus.s_address = 2'd0;
        #1;
        check("mid_m_address", 32'(bus.m_address), 32'd0);
        check("mid_m_read",    32'(bus.m_read),    32'd0);
        check("mid_ok",        32'(sysid_ok),      32'd0);
        check("mid_fail",      32'(sysid_fail),    32'd0);
        check("mid_status",    bus.s_readdata,     32'd0);
        exp_addr_q.delete();
        exp_res_q.delete();
        expect_run(1'b1, 1'b0, 32'h03, c_exp_id, c_exp_ts, 2);
        tick();
        rst_n = 1'b1;
        wait_done("mid", 100, n);
        compare_result("mid");

        // Timeout: waitrequest held forever, no response
        rsp_stall = 1000000; rsp_delay = 0; rsp_enable = 1'b0; timeout_mode = 1'b1;
        tick();
        rst_n = 1'b0;
        exp_addr_q.delete();
        exp_res_q.delete();
        expect_run(1'b0, 1'b1, 32'h11, 32'd0, 32'd0, 1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            if (c == 15) check("to_m_read_c15", 32'(bus.m_read), 32'd1);
            if (c == 16) check("to_m_read_c16", 32'(bus.m_read), 32'd0);
        end
        compare_result("to");
        tick();
        pend_data = c_exp_id;
        pend_left = 1;
        tick();
        tick();
        read_reg(2'd0, d); check("late_status", d, 32'h11);
        read_reg(2'd1, d); check("late_cap_id", d, 32'd0);
        write_reg(2'd0, 32'd1);
        read_reg(2'd0, d); check("wr_addr0_status", d, 32'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
